// File: rtl/qspi_rle_fetcher.sv
// qspi_rle_fetcher: streams 16-bit RLE words from a QSPI flash (Fast Read
// Quad Output, 0x6B) starting at START_ADDR, buffers them in a small FIFO and
// hands them to the RLE decoder. stop_data aborts and restarts the stream.
module qspi_rle_fetcher #(
  parameter logic [23:0] START_ADDR     = 24'h000000,
  parameter int          FIFO_DEPTH     = 2,
  parameter int          CS_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_next,
  input  logic        stop_data,
  output logic        data_ready,
  output logic [15:0] data,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic [3:0]  spi_d_out,
  output logic [3:0]  spi_d_oe,
  input  logic [3:0]  spi_d_in
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;

  localparam logic [7:0] CMD_QOR = 8'h6B;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CS_HIGH_CYCLES + 1);
  localparam logic [CW-1:0] CS_LAST = CW'(CS_HIGH_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);

  logic [2:0]    state;
  logic          ph;        // 0: spi_clk low half, 1: spi_clk high half
  logic [5:0]    bcnt;      // SPI clocks elapsed in CMD/ADDR/DUMMY
  logic [31:0]   sh;        // remaining command/address bits, MSB next
  logic [CW-1:0] cs_cnt;
  logic [1:0]    nib;
  logic [11:0]   word_sr;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop, head_from_push;
  logic [15:0]   push_word;

  // the 4th nibble completes a word; a stop in the same cycle discards it
  always_comb begin
    push           = (state == S_DATA) && ph && (nib == 2'd3) && !stop_data;
    pop            = read_next && (count != '0) && !stop_data;
    push_word      = {word_sr, spi_d_in};
    count_nxt      = count;
    if (push && !pop)      count_nxt = count + ONE_C;
    else if (!push && pop) count_nxt = count - ONE_C;
    // the FIFO is (or becomes) empty before this push lands, so the pushed word is the new head
    head_from_push = push && ((count == '0) || (pop && (count == ONE_C)));
  end

  // transaction sequencer: IDLE gap, then CMD/ADDR/DUMMY shift-out, then nibble capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ph        <= 1'b0;
      bcnt      <= '0;
      sh        <= '0;
      cs_cnt    <= '0;
      nib       <= '0;
      word_sr   <= '0;
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_d_out <= '0;
      spi_d_oe  <= '0;
    end else if (stop_data) begin
      state     <= S_IDLE;
      ph        <= 1'b0;
      bcnt      <= '0;
      cs_cnt    <= '0;
      nib       <= '0;
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_d_out <= '0;
      spi_d_oe  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_cnt == CS_LAST) begin
            state     <= S_CMD;
            cs_cnt    <= '0;
            ph        <= 1'b0;
            bcnt      <= '0;
            spi_cs_n  <= 1'b0;
            spi_clk   <= 1'b0;
            spi_d_out <= {3'b000, CMD_QOR[7]};
            spi_d_oe  <= 4'b0001;
            sh        <= {CMD_QOR[6:0], START_ADDR, 1'b0};
          end else begin
            cs_cnt <= cs_cnt + CW'(1);
          end
        end
        S_CMD, S_ADDR, S_DUMMY: begin
          if (!ph) begin
            ph      <= 1'b1;
            spi_clk <= 1'b1;
          end else begin
            ph        <= 1'b0;
            spi_clk   <= 1'b0;
            bcnt      <= bcnt + 6'd1;
            sh        <= {sh[30:0], 1'b0};
            spi_d_out <= {3'b000, sh[31]};
            if (bcnt == 6'd7) state <= S_ADDR;
            if (bcnt == 6'd31) begin
              state     <= S_DUMMY;
              spi_d_out <= '0;
              spi_d_oe  <= '0;
            end
            if (bcnt == 6'd39) begin
              state <= S_DATA;
              nib   <= '0;
            end
          end
        end
        S_DATA: begin
          if (!ph) begin
            // only start a new word when it is guaranteed a free slot; otherwise stretch spi_clk low
            if ((nib != 2'd0) || (count < DEPTH_C)) begin
              ph      <= 1'b1;
              spi_clk <= 1'b1;
            end
          end else begin
            ph      <= 1'b0;
            spi_clk <= 1'b0;
            word_sr <= {word_sr[7:0], spi_d_in};
            nib     <= nib + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // word storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, count and the registered head/ready outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_ready <= 1'b0;
      data       <= '0;
    end else if (stop_data) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_nxt;
      data_ready <= (count_nxt != '0);
      if (head_from_push) data <= push_word;
      else if (pop && (count > ONE_C)) data <= mem[rd_ptr + AW'(1)];
    end
  end

endmodule

// File: tb/tb_qspi_rle_fetcher.sv
// Directed bench for qspi_rle_fetcher with a behavioural quad-output flash.
module tb_qspi_rle_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_next;
  logic        stop_data;
  logic        data_ready;
  logic [15:0] data;
  logic        spi_cs_n;
  logic        spi_clk;
  logic [3:0]  spi_d_out;
  logic [3:0]  spi_d_oe;
  logic [3:0]  spi_d_in = 4'h0;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_idx = 0;

  qspi_rle_fetcher #(
    .START_ADDR(24'h000000),
    .FIFO_DEPTH(2),
    .CS_HIGH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .read_next(read_next),
    .stop_data(stop_data),
    .data_ready(data_ready),
    .data(data),
    .spi_cs_n(spi_cs_n),
    .spi_clk(spi_clk),
    .spi_d_out(spi_d_out),
    .spi_d_oe(spi_d_oe),
    .spi_d_in(spi_d_in)
  );

  always #5 clk = ~clk;

  // flash contents as 16-bit big-endian words; tiny array so it wraps
  function automatic logic [15:0] flash_word(input int i);
    case (i % 8)
      0: return 16'h1234;
      1: return 16'hABCD;
      2: return 16'h5A5A;
      3: return 16'h0F0F;
      4: return 16'hC3E1;
      5: return 16'h9876;
      6: return 16'hFEDC;
      default: return 16'h0246;
    endcase
  endfunction

  function automatic logic [3:0] nib_of(input logic [23:0] a, input int n);
    logic [15:0] w;
    w = flash_word(int'(a >> 1) + n / 4);
    case (n % 4)
      0: return w[15:12];
      1: return w[11:8];
      2: return w[7:4];
      default: return w[3:0];
    endcase
  endfunction

  // flash model: capture cmd/addr on rising spi_clk, drive nibbles after 40 clocks
  int          fcnt = 0;
  int          f_nib = 0;
  logic [7:0]  f_cmd = 8'h00;
  logic [23:0] f_addr = 24'hFFFFFF;

  always @(posedge spi_clk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      fcnt   <= 0;
      f_nib  <= 0;
      f_cmd  <= 8'h00;
      f_addr <= 24'hFFFFFF;
    end else begin
      if (fcnt < 8) f_cmd <= {f_cmd[6:0], spi_d_out[0]};
      else if (fcnt < 32) f_addr <= {f_addr[22:0], spi_d_out[0]};
      if (fcnt >= 40) begin
        spi_d_in <= nib_of(f_addr, f_nib);
        f_nib    <= f_nib + 1;
      end
      fcnt <= fcnt + 1;
    end
  end

  task automatic wait_ready(input int max, output int cyc);
    cyc = 0;
    while (cyc < max && !data_ready) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic pulse_stop();
    stop_data = 1'b1;
    @(posedge clk); #1;
    stop_data = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    bit seen;
    logic [26:0] got;
    repeat (3) @(posedge clk);
    #1;
    got = {spi_cs_n, spi_clk, spi_d_out, spi_d_oe, data_ready, data};
    n_cmp++;
    if (got !== 27'h4000000) begin
      n_bad++;
      $display("FAIL reset_values: got %h want %h", got, 27'h4000000);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    seen = 0;
    while (cyc < 10 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (!spi_cs_n) seen = 1;
    end
    n_cmp++;
    if (!seen || cyc != 2) begin
      n_bad++;
      $display("FAIL cs_fall_latency: got %0d want 2", cyc);
    end
    while (cyc < 200 && !data_ready) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc != 90) begin
      n_bad++;
      $display("FAIL first_word_latency: got %0d want 90", cyc);
    end
    n_cmp++;
    if (data !== 16'h1234) begin
      n_bad++;
      $display("FAIL first_word: got %h want 1234", data);
    end
    n_cmp++;
    if (f_cmd !== 8'h6B || f_addr !== 24'h000000) begin
      n_bad++;
      $display("FAIL cmd_addr: got %h/%h want 6b/000000", f_cmd, f_addr);
    end
    read_next = 1'b1;
    @(posedge clk); #1;
    read_next = 1'b0;
    n_cmp++;
    if (data_ready !== 1'b0 || data !== 16'h1234) begin
      n_bad++;
      $display("FAIL pop_to_empty: got rdy=%b data=%h want rdy=0 data=1234", data_ready, data);
    end
    wait_ready(20, cyc);
    n_cmp++;
    if (!data_ready || data !== 16'hABCD) begin
      n_bad++;
      $display("FAIL second_word: got rdy=%b data=%h want rdy=1 data=abcd", data_ready, data);
    end
  endtask

  task automatic test_stall();
    bit moved;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (f_nib != 12) begin
      n_bad++;
      $display("FAIL stall_fill: got %0d nibbles want 12", f_nib);
    end
    moved = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (spi_clk || spi_cs_n) moved = 1;
    end
    n_cmp++;
    if (moved) begin
      n_bad++;
      $display("FAIL stall_hold: got spi_clk/cs activity want clk low cs low");
    end
    n_cmp++;
    if (!data_ready || data !== 16'hABCD) begin
      n_bad++;
      $display("FAIL stall_head: got rdy=%b data=%h want rdy=1 data=abcd", data_ready, data);
    end
    read_next = 1'b1;
    @(posedge clk); #1;
    read_next = 1'b0;
    n_cmp++;
    if (data !== flash_word(2)) begin
      n_bad++;
      $display("FAIL stall_pop: got %h want %h", data, flash_word(2));
    end
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (f_nib != 16 || spi_clk || spi_cs_n || data !== flash_word(2)) begin
      n_bad++;
      $display("FAIL stall_one_more: got nib=%0d clk=%b cs=%b data=%h want 16 0 0 %h",
               f_nib, spi_clk, spi_cs_n, data, flash_word(2));
    end
    exp_idx = 2;
  endtask

  task automatic test_back_to_back();
    int prev_pop, last_pop, empty_cycles, npop;
    bit had;
    logic [15:0] hd;
    prev_pop = -1;
    last_pop = -1;
    empty_cycles = 0;
    npop = 0;
    had = data_ready;
    hd = data;
    read_next = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      if (had) begin
        n_cmp++;
        if (hd !== flash_word(exp_idx)) begin
          n_bad++;
          $display("FAIL stream_word%0d: got %h want %h", exp_idx, hd, flash_word(exp_idx));
        end
        exp_idx++;
        npop++;
        prev_pop = last_pop;
        last_pop = cyc;
      end
      if (!data_ready) empty_cycles++;
      had = data_ready;
      hd = data;
    end
    read_next = 1'b0;
    n_cmp++;
    if (last_pop - prev_pop != 8) begin
      n_bad++;
      $display("FAIL stream_rate: got %0d cycles/word want 8", last_pop - prev_pop);
    end
    n_cmp++;
    if (empty_cycles == 0 || npop < 10) begin
      n_bad++;
      $display("FAIL stream_pulses: got empty=%0d pops=%0d want empty>0 pops>=10", empty_cycles, npop);
    end
  endtask

  task automatic test_stop();
    int cyc;
    pulse_stop();
    wait_ready(200, cyc);
    n_cmp++;
    if (cyc != 90 || data !== 16'h1234) begin
      n_bad++;
      $display("FAIL stop_restart: got cyc=%0d data=%h want 90 1234", cyc, data);
    end
    repeat (3) @(posedge clk);
    #1;
    stop_data = 1'b1;
    read_next = 1'b1;
    @(posedge clk); #1;
    stop_data = 1'b0;
    read_next = 1'b0;
    n_cmp++;
    if (spi_cs_n !== 1'b1 || spi_clk !== 1'b0 || spi_d_oe !== 4'h0 || data_ready !== 1'b0 || data !== 16'h1234) begin
      n_bad++;
      $display("FAIL stop_midword: got cs=%b clk=%b oe=%h rdy=%b data=%h want 1 0 0 0 1234",
               spi_cs_n, spi_clk, spi_d_oe, data_ready, data);
    end
    exp_idx = 0;
    wait_ready(200, cyc);
    n_cmp++;
    if (cyc != 90 || data !== 16'h1234) begin
      n_bad++;
      $display("FAIL stop_second_restart: got cyc=%0d data=%h want 90 1234", cyc, data);
    end
  endtask

  task automatic test_rst_mid();
    int cyc;
    logic [26:0] got;
    pulse_stop();
    repeat (2 + 31) @(posedge clk);
    #1;
    n_cmp++;
    if (spi_cs_n !== 1'b0 || spi_d_oe !== 4'b0001) begin
      n_bad++;
      $display("FAIL in_addr: got cs=%b oe=%h want 0 1", spi_cs_n, spi_d_oe);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    got = {spi_cs_n, spi_clk, spi_d_out, spi_d_oe, data_ready, data};
    n_cmp++;
    if (got !== 27'h4000000) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", got, 27'h4000000);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_ready(200, cyc);
    n_cmp++;
    if (cyc != 90 || data !== 16'h1234 || f_cmd !== 8'h6B || f_addr !== 24'h000000) begin
      n_bad++;
      $display("FAIL rst_restart: got cyc=%0d data=%h cmd=%h addr=%h want 90 1234 6b 000000",
               cyc, data, f_cmd, f_addr);
    end
  endtask

  task automatic test_push_pop();
    int cyc;
    pulse_stop();
    wait_ready(200, cyc);
    repeat (7) @(posedge clk);
    #1;
    read_next = 1'b1;
    @(posedge clk); #1;
    read_next = 1'b0;
    n_cmp++;
    if (!data_ready || data !== 16'hABCD) begin
      n_bad++;
      $display("FAIL push_pop_same: got rdy=%b data=%h want 1 abcd", data_ready, data);
    end
    read_next = 1'b1;
    @(posedge clk); #1;
    read_next = 1'b0;
    n_cmp++;
    if (data_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL push_pop_count: got rdy=%b want 0", data_ready);
    end
    wait_ready(20, cyc);
    n_cmp++;
    if (!data_ready || data !== flash_word(2)) begin
      n_bad++;
      $display("FAIL push_pop_next: got rdy=%b data=%h want 1 %h", data_ready, data, flash_word(2));
    end
  endtask

  initial begin
    rst = 1'b0;
    read_next = 1'b0;
    stop_data = 1'b0;
    #1;
    rst = 1'b1;
    test_reset();
    test_stall();
    test_back_to_back();
    test_stop();
    test_rst_mid();
    test_push_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
